// File: rtl/cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_pkg : shared widths and MEM-stage FSM encoding
// Rev 1.0
// ----------------------------------------------------------------------------
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int RD_W   = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;
endpackage
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_wb_reg : MEM/WB boundary register with load enable, async active-low reset
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_wb_reg #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int RD_W   = cpu_pkg::RD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_regwrite,
    input  logic              i_memtoreg,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [DATA_W-1:0] i_out,
    input  logic [RD_W-1:0]   i_rd,
    output logic              o_regwrite,
    output logic              o_memtoreg,
    output logic [DATA_W-1:0] o_rdata,
    output logic [DATA_W-1:0] o_out,
    output logic [RD_W-1:0]   o_rd
);
    logic              r_regwrite;
    logic              r_memtoreg;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_out;
    logic [RD_W-1:0]   r_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_rdata    <= '0;
            r_out      <= '0;
            r_rd       <= '0;
        end else if (i_en) begin
            r_regwrite <= i_regwrite;
            r_memtoreg <= i_memtoreg;
            r_rdata    <= i_rdata;
            r_out      <= i_out;
            r_rd       <= i_rd;
        end
    end

    assign o_regwrite = r_regwrite;
    assign o_memtoreg = r_memtoreg;
    assign o_rdata    = r_rdata;
    assign o_out      = r_out;
    assign o_rd       = r_rd;
endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_stage : data-memory access over req/ready with upstream stall, MEM/WB out
// Optional watchdog: define MEM_TIMEOUT_EN.   Rev 1.0
// ----------------------------------------------------------------------------
module mem_stage #(
    parameter int DATA_W         = cpu_pkg::DATA_W,
    parameter int ADDR_W         = cpu_pkg::ADDR_W,
    parameter int RD_W           = cpu_pkg::RD_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MEM_regwrite,
    input  logic              MEM_memtoreg,
    input  logic              MEM_memread,
    input  logic              MEM_memwrite,
    input  logic [DATA_W-1:0] MEM_out,
    input  logic [DATA_W-1:0] MEM_wdata,
    input  logic [RD_W-1:0]   MEM_rd,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              WB_regwrite,
    output logic              WB_memtoreg,
    output logic [DATA_W-1:0] WB_rdata,
    output logic [DATA_W-1:0] WB_out,
    output logic [RD_W-1:0]   WB_rd,
    output logic              mem_err
);
    import cpu_pkg::*;

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_h_regwrite;
    logic              r_h_memtoreg;
    logic              r_h_we;
    logic [RD_W-1:0]   r_h_rd;
    logic [DATA_W-1:0] r_h_out;
    logic [DATA_W-1:0] r_h_wdata;

    logic              w_busy;
    logic              w_memop;
    logic              w_timeout;
    logic              w_wb_en;
    logic              w_wb_regwrite;
    logic              w_wb_memtoreg;
    logic [DATA_W-1:0] w_wb_rdata;
    logic [DATA_W-1:0] w_wb_out;
    logic [RD_W-1:0]   w_wb_rd;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign w_busy  = (r_state == BUSY);
    assign w_memop = MEM_memread | MEM_memwrite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_h_regwrite <= 1'b0;
            r_h_memtoreg <= 1'b0;
            r_h_we       <= 1'b0;
            r_h_rd       <= '0;
            r_h_out      <= '0;
            r_h_wdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_busy && w_memop) begin
                r_h_regwrite <= MEM_regwrite;
                r_h_memtoreg <= MEM_memtoreg;
                r_h_we       <= MEM_memwrite;
                r_h_rd       <= MEM_rd;
                r_h_out      <= MEM_out;
                r_h_wdata    <= MEM_wdata;
            end
        end
    end

    // Bubbles keep the surrounding fields but never enable a register write.
    always_comb begin
        w_state_nxt   = r_state;
        w_wb_en       = 1'b0;
        w_wb_regwrite = 1'b0;
        w_wb_memtoreg = MEM_memtoreg;
        w_wb_rdata    = '0;
        w_wb_out      = MEM_out;
        w_wb_rd       = MEM_rd;
        case (r_state)
            IDLE: begin
                w_wb_en = 1'b1;
                if (w_memop) begin
                    w_state_nxt = BUSY;
                end else begin
                    w_wb_regwrite = MEM_regwrite;
                end
            end
            BUSY: begin
                w_wb_memtoreg = r_h_memtoreg;
                w_wb_out      = r_h_out;
                w_wb_rd       = r_h_rd;
                if (dmem_ready) begin
                    w_wb_en       = 1'b1;
                    w_wb_regwrite = r_h_regwrite;
                    w_wb_rdata    = r_h_we ? '0 : dmem_rdata;
                    w_state_nxt   = IDLE;
                end else if (w_timeout) begin
                    w_wb_en     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Ready on the limit edge wins, so the timeout is qualified by ~dmem_ready.
    assign w_timeout = w_busy & ~dmem_ready & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (!w_busy) begin
                r_cnt <= '0;
            end else if (!dmem_ready) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
`endif

    assign mem_stall  = w_busy;
    assign dmem_req   = w_busy;
    assign dmem_we    = r_h_we;
    assign dmem_addr  = r_h_out[ADDR_W-1:0];
    assign dmem_wdata = r_h_wdata;

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_mem_wb_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (w_wb_en),
        .i_regwrite (w_wb_regwrite),
        .i_memtoreg (w_wb_memtoreg),
        .i_rdata    (w_wb_rdata),
        .i_out      (w_wb_out),
        .i_rd       (w_wb_rd),
        .o_regwrite (WB_regwrite),
        .o_memtoreg (WB_memtoreg),
        .o_rdata    (WB_rdata),
        .o_out      (WB_out),
        .o_rd       (WB_rd)
    );
endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_stage : scoreboard bench for mem_stage (timeout cases with MEM_TIMEOUT_EN)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_stage;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int RD_W   = 3;
    localparam int TMO    = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              MEM_regwrite, MEM_memtoreg, MEM_memread, MEM_memwrite;
    logic [DATA_W-1:0] MEM_out, MEM_wdata;
    logic [RD_W-1:0]   MEM_rd;
    logic              mem_stall, dmem_req, dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ready = 1'b0;
    logic [DATA_W-1:0] dmem_rdata = '0;
    logic              WB_regwrite, WB_memtoreg;
    logic [DATA_W-1:0] WB_rdata, WB_out;
    logic [RD_W-1:0]   WB_rd;
    logic              mem_err;

    always #5 clk = ~clk;

    mem_stage #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .RD_W           (RD_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MEM_regwrite (MEM_regwrite),
        .MEM_memtoreg (MEM_memtoreg),
        .MEM_memread  (MEM_memread),
        .MEM_memwrite (MEM_memwrite),
        .MEM_out      (MEM_out),
        .MEM_wdata    (MEM_wdata),
        .MEM_rd       (MEM_rd),
        .mem_stall    (mem_stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rdata   (dmem_rdata),
        .WB_regwrite  (WB_regwrite),
        .WB_memtoreg  (WB_memtoreg),
        .WB_rdata     (WB_rdata),
        .WB_out       (WB_out),
        .WB_rd        (WB_rd),
        .mem_err      (mem_err)
    );

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic              mem;
        logic              we;
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] out;
        logic [DATA_W-1:0] wdata;
        logic [RD_W-1:0]   rd;
    } exp_t;

    exp_t              sb_q[$];
    int                rsp_dly_q[$];
    logic [DATA_W-1:0] rsp_data_q[$];

    int   n_vec   = 0;
    int   n_err   = 0;
    logic mon_en  = 1'b0;
    logic exp_err = 1'b0;
    logic tb_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        MEM_regwrite = 1'b0;
        MEM_memtoreg = 1'b0;
        MEM_memread  = 1'b0;
        MEM_memwrite = 1'b0;
        MEM_out      = '0;
        MEM_wdata    = '0;
        MEM_rd       = '0;
        tb_valid     = 1'b0;
    endtask

    // Drives one op at posedge+1 and holds it until the stage takes it.
    task automatic send(input logic rw, input logic m2r, input logic mr, input logic mw,
                        input logic [DATA_W-1:0] out, input logic [DATA_W-1:0] wdata,
                        input logic [RD_W-1:0] rd, input int dly,
                        input logic [DATA_W-1:0] rdata, output int waited);
        logic was_stall;
        exp_t e;
        MEM_regwrite = rw;
        MEM_memtoreg = m2r;
        MEM_memread  = mr;
        MEM_memwrite = mw;
        MEM_out      = out;
        MEM_wdata    = wdata;
        MEM_rd       = rd;
        tb_valid     = 1'b1;
        waited       = 0;
        do begin
            was_stall = mem_stall;
            @(posedge clk);
            #1;
            waited++;
        end while (was_stall && waited < 200);
        if (was_stall) check_eq("accept_wait", waited, 0);
        e.regwrite = rw;
        e.memtoreg = m2r;
        e.mem      = mr | mw;
        e.we       = mw;
        e.rdata    = (mr && !mw) ? rdata : '0;
        e.out      = out;
        e.wdata    = wdata;
        e.rd       = rd;
        sb_q.push_back(e);
        if (mr || mw) begin
            rsp_dly_q.push_back(dly);
            rsp_data_q.push_back(rdata);
        end
    endtask

    // Memory model: dly counts BUSY cycles until ready; 0 never answers.
    initial begin
        int cnt = 0;
        int dly = 0;
        logic [DATA_W-1:0] data = '0;
        forever begin
            @(posedge clk);
            #2;
            if (dmem_req) begin
                if (cnt == 0) begin
                    dly  = (rsp_dly_q.size() > 0) ? rsp_dly_q.pop_front() : 0;
                    data = (rsp_data_q.size() > 0) ? rsp_data_q.pop_front() : '0;
                end
                cnt++;
                dmem_ready = (cnt == dly);
                dmem_rdata = (cnt == dly) ? data : $urandom;
            end else begin
                cnt        = 0;
                dmem_ready = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
        end
    end

    // Monitor: classify each edge from pre-edge values, then check after it.
    initial begin
        logic p_stall, p_req, p_rdy, p_memop, p_valid;
        exp_t e;
        forever begin
            @(negedge clk);
            p_stall = mem_stall;
            p_req   = dmem_req;
            p_rdy   = dmem_ready;
            p_memop = MEM_memread | MEM_memwrite;
            p_valid = tb_valid;
            @(posedge clk);
            #3;
            if (mon_en) begin
                check_eq("mem_err", mem_err, exp_err);
                if ((p_req && p_rdy) || (!p_stall && !p_memop && p_valid)) begin
                    check_eq("sb_nonempty", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check_eq("wb_regwrite", WB_regwrite, e.regwrite);
                        check_eq("wb_memtoreg", WB_memtoreg, e.memtoreg);
                        check_eq("wb_rdata", WB_rdata, e.rdata);
                        check_eq("wb_out", WB_out, e.out);
                        check_eq("wb_rd", WB_rd, e.rd);
                        check_eq("req_after_wb", dmem_req, 0);
                        check_eq("stall_after_wb", mem_stall, 0);
                    end
                end else if (!p_stall && !p_memop) begin
                    check_eq("nop_wb_regwrite", WB_regwrite, 0);
                end else begin
                    check_eq("busy_stall", mem_stall, 1);
                    check_eq("busy_req", dmem_req, 1);
                    check_eq("bubble_regwrite", WB_regwrite, 0);
                    if (sb_q.size() > 0) begin
                        check_eq("req_we", dmem_we, sb_q[0].we);
                        check_eq("req_addr", dmem_addr, sb_q[0].out[ADDR_W-1:0]);
                        check_eq("req_wdata", dmem_wdata, sb_q[0].wdata);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int w;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_wb_regwrite", WB_regwrite, 0);
        check_eq("rst_wb_memtoreg", WB_memtoreg, 0);
        check_eq("rst_wb_rdata", WB_rdata, 0);
        check_eq("rst_wb_out", WB_out, 0);
        check_eq("rst_wb_rd", WB_rd, 0);
        check_eq("rst_req", dmem_req, 0);
        check_eq("rst_stall", mem_stall, 0);
        check_eq("rst_mem_err", mem_err, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        send(1, 0, 0, 0, 32'h0000_00A5, 32'h0, 3'd3, 0, 32'h0, w);
        send(1, 1, 1, 0, 32'h0000_0040, 32'h5555_AAAA, 3'd5, 3, 32'hDEAD_BEEF, w);
        send(1, 0, 0, 0, 32'h0000_0077, 32'h0, 3'd2, 0, 32'h0, w);
        check_eq("alu_after_load_wait", w, 4);
        send(0, 0, 0, 1, 32'h0000_0010, 32'h1234_5678, 3'd0, 1, 32'h0, w);
        send(1, 0, 0, 1, 32'h1234_0020, 32'hCAFE_F00D, 3'd6, 2, 32'h0, w);
        check_eq("store_gap", w, 2);
        send(1, 1, 1, 1, 32'h0000_0030, 32'hFEED_0001, 3'd7, 1, 32'h0BAD_0BAD, w);
        check_eq("store_rw_gap", w, 3);
        send(1, 1, 1, 0, 32'h0000_0044, 32'h0, 3'd1, 1, 32'h1111_2222, w);
        send(1, 1, 1, 0, 32'h0000_0048, 32'h0, 3'd4, 1, 32'h3333_4444, w);
        check_eq("b2b_load_gap", w, 2);
        send(0, 1, 0, 0, 32'hFFFF_FFFF, 32'h0, 3'd7, 0, 32'h0, w);
        idle();
        repeat (3) @(posedge clk);
        #1;

        // Reset in the second BUSY cycle of a load that is never answered.
        mon_en = 1'b0;
        send(1, 1, 1, 0, 32'h0000_0080, 32'h0, 3'd1, 0, 32'h0, w);
        idle();
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_req", dmem_req, 0);
        check_eq("rstmid_stall", mem_stall, 0);
        check_eq("rstmid_wb_out", WB_out, 0);
        check_eq("rstmid_wb_rd", WB_rd, 0);
        check_eq("rstmid_wb_memtoreg", WB_memtoreg, 0);
        sb_q.delete();
        rsp_dly_q.delete();
        rsp_data_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        send(1, 0, 0, 0, 32'h0000_005A, 32'h0, 3'd4, 0, 32'h0, w);
        send(1, 1, 1, 0, 32'h0000_0050, 32'h0, 3'd6, 2, 32'hA5A5_5A5A, w);
        idle();
        repeat (4) @(posedge clk);
        #1;

`ifdef MEM_TIMEOUT_EN
        mon_en = 1'b0;
        send(1, 0, 1, 0, 32'h0000_0090, 32'h0, 3'd2, 0, 32'h0, w);
        idle();
        for (int i = 0; i < TMO; i++) begin
            check_eq("tmo_req_held", dmem_req, 1);
            @(posedge clk);
            #1;
        end
        check_eq("tmo_req_drop", dmem_req, 0);
        check_eq("tmo_stall", mem_stall, 0);
        check_eq("tmo_err", mem_err, 1);
        check_eq("tmo_wb_regwrite", WB_regwrite, 0);
        sb_q.delete();
        exp_err = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        send(1, 0, 0, 0, 32'h0000_0011, 32'h0, 3'd3, 0, 32'h0, w);
        send(1, 1, 1, 0, 32'h0000_0060, 32'h0, 3'd5, TMO, 32'h7777_8888, w);
        idle();
        repeat (TMO + 3) @(posedge clk);
        #1;
        check_eq("tmo_err_sticky", mem_err, 1);
`endif

        check_eq("sb_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
